// File: rtl/datapath_seq.sv
// datapath_seq: multi-cycle control sequencer for a simple register/ALU datapath.
// Latches an instruction on start, decodes it, and steps through operand fetch,
// execute and write-back states, driving Moore-style datapath controls.
// Optional feature: define DATAPATH_SEQ_RETIRE_CNT_EN to add a 16-bit
// retired-instruction counter output.
module datapath_seq #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic [DATA_W-1:0] ir,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic              write,
    output logic              shift_ctrl,
    output logic [1:0]        vsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [2:0]        writenum,
    output logic [2:0]        readnum,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5,
    output logic              w,
    output logic              err
`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]       retired
`endif
);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_DECODE,
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_WR_REG,
        ST_WR_IMM,
        ST_ERR
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] instr;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_mvn;
    logic       is_cmp;

    // Instruction field split and opcode classification from the latched instr
    always_comb begin
        opcode     = instr[15:13];
        op         = instr[12:11];
        rn         = instr[10:8];
        rd         = instr[7:5];
        sh         = instr[4:3];
        rm         = instr[2:0];
        is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
        is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
        is_alu     = (opcode == 3'b101);
        is_mvn     = is_alu && (op == 2'b11);
        is_cmp     = is_alu && (op == 2'b01);
    end

    // State register and instruction latch; start is only honoured in WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_WAIT;
            instr <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (s) begin
                        instr <= ir;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_mov_imm)
                        state <= ST_WR_IMM;
                    else if (is_mov_reg || is_mvn)
                        state <= ST_GET_B;
                    else if (is_alu)
                        state <= ST_GET_A;
                    else
                        state <= ST_ERR;
                end
                ST_GET_A:  state <= ST_GET_B;
                ST_GET_B:  state <= ST_EXEC;
                ST_EXEC:   state <= is_cmp ? ST_WAIT : ST_WR_REG;
                ST_WR_REG: state <= ST_WAIT;
                ST_WR_IMM: state <= ST_WAIT;
                ST_ERR:    state <= ST_WAIT;
                default:   state <= ST_WAIT;
            endcase
        end
    end

    // Moore control decode; reset masks the state-changing strobes immediately
    always_comb begin
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        write      = 1'b0;
        shift_ctrl = 1'b0;
        vsel       = 2'b00;
        shift      = 2'b00;
        ALUop      = 2'b00;
        writenum   = 3'd0;
        readnum    = 3'd0;
        w          = 1'b0;
        err        = 1'b0;
        sximm8     = {{(DATA_W-8){instr[7]}}, instr[7:0]};
        sximm5     = {{(DATA_W-5){instr[4]}}, instr[4:0]};
        case (state)
            ST_WAIT: w = 1'b1;
            ST_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            ST_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            ST_EXEC: begin
                shift = sh;
                bsel  = 1'b0;
                asel  = is_mov_reg || is_mvn;
                ALUop = is_alu ? op : 2'b00;
                if (is_cmp)
                    loads = 1'b1;
                else
                    loadc = 1'b1;
            end
            ST_WR_REG: begin
                vsel     = 2'b00;
                writenum = rd;
                write    = 1'b1;
            end
            ST_WR_IMM: begin
                vsel     = 2'b10;
                writenum = rn;
                write    = 1'b1;
            end
            ST_ERR: err = 1'b1;
            default: ;
        endcase
        if (reset) begin
            write = 1'b0;
            loada = 1'b0;
            loadb = 1'b0;
            loadc = 1'b0;
            loads = 1'b0;
            err   = 1'b0;
        end
    end

`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
    // Retired counter: counts completing instructions, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset)
            retired <= '0;
        else if (state == ST_WR_REG || state == ST_WR_IMM || (state == ST_EXEC && is_cmp))
            retired <= retired + 16'd1;
    end
`endif

endmodule
